// File: rtl/mac_window_pkg.sv
// Shared types and range-limit helpers for the sliding-window multiply-add pipe.
package mac_window_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    localparam logic [1:0] RUN_FULL = 2'd2;

    // Wide enough for the full-precision result of any DW up to 64.
    localparam int unsigned MAX_W = 130;

    function automatic logic signed [MAX_W-1:0] range_max(input int unsigned ow, input bit is_signed);
        logic signed [MAX_W-1:0] one;
        one = 1;
        if (is_signed)
            return (one <<< (ow - 1)) - one;
        else
            return (one <<< ow) - one;
    endfunction

    function automatic logic signed [MAX_W-1:0] range_min(input int unsigned ow, input bit is_signed);
        logic signed [MAX_W-1:0] one;
        one = 1;
        if (is_signed)
            return -(one <<< (ow - 1));
        else
            return '0;
    endfunction

endpackage

// File: rtl/mac_window_arith.sv
// Combinational a*b +/- c with range check and saturate-or-wrap to OW bits.
module mac_window_arith
    import mac_window_pkg::*;
#(
    parameter int DW     = 32,
    parameter int OW     = 32,
    parameter int SIGNED = 0,
    parameter int SAT    = 0
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    input  logic          mode,
    output logic [OW-1:0] result,
    output logic          ovf
);

    // One bit beyond 2*DW+1 so an unsigned difference below zero stays representable.
    localparam int RW = 2 * DW + 2;

    localparam logic signed [MAX_W-1:0] LIM_MAX = range_max(OW, SIGNED != 0);
    localparam logic signed [MAX_W-1:0] LIM_MIN = range_min(OW, SIGNED != 0);

    logic signed [RW-1:0]    a_x;
    logic signed [RW-1:0]    b_x;
    logic signed [RW-1:0]    c_x;
    logic signed [RW-1:0]    prod;
    logic signed [RW-1:0]    sum;
    logic signed [MAX_W-1:0] r_ext;
    logic                    over;
    logic                    under;

    always_comb begin
        if (SIGNED != 0) begin
            a_x = RW'(signed'(a));
            b_x = RW'(signed'(b));
            c_x = RW'(signed'(c));
        end else begin
            a_x = RW'(a);
            b_x = RW'(b);
            c_x = RW'(c);
        end
        prod = a_x * b_x;
        if (mode_e'(mode) == MODE_SUB)
            sum = prod - c_x;
        else
            sum = prod + c_x;
        r_ext = MAX_W'(sum);
        over  = (r_ext > LIM_MAX);
        under = (r_ext < LIM_MIN);
        ovf   = over | under;
        if (SAT != 0 && over)
            result = LIM_MAX[OW-1:0];
        else if (SAT != 0 && under)
            result = LIM_MIN[OW-1:0];
        else
            result = sum[OW-1:0];
    end

endmodule

// File: rtl/mac_window_pipe.sv
// Streaming data_out = s[t-2]*s[t-1] +/- s[t] over runs of consecutive valid samples.
module mac_window_pipe
    import mac_window_pkg::*;
#(
    parameter int DW     = 32,
    parameter int OW     = 32,
    parameter int SIGNED = 0,
    parameter int SAT    = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          validi,
    input  logic [DW-1:0] data_in,
    input  logic          mode,
    input  logic          flush,
    output logic          valido,
    output logic [OW-1:0] data_out,
    output logic          ovf,
    output logic [1:0]    run_cnt
);

    logic [DW-1:0] s1;
    logic [DW-1:0] s2;
    logic [OW-1:0] res_n;
    logic          ovf_n;

    mac_window_arith #(
        .DW     (DW),
        .OW     (OW),
        .SIGNED (SIGNED),
        .SAT    (SAT)
    ) u_arith (
        .a      (s2),
        .b      (s1),
        .c      (data_in),
        .mode   (mode),
        .result (res_n),
        .ovf    (ovf_n)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1       <= '0;
            s2       <= '0;
            run_cnt  <= '0;
            valido   <= 1'b0;
            ovf      <= 1'b0;
            data_out <= '0;
        end else begin
            valido <= 1'b0;
            if (validi) begin
                s2 <= s1;
                s1 <= data_in;
                // A flushed sample starts a new run rather than completing the old one.
                if (flush) begin
                    run_cnt <= 2'd1;
                end else if (run_cnt == RUN_FULL) begin
                    valido   <= 1'b1;
                    data_out <= res_n;
                    ovf      <= ovf_n;
                end else begin
                    run_cnt <= run_cnt + 2'd1;
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mac_window_pipe.sv
// Directed bench for mac_window_pipe across default, signed and 8-bit overflow builds.
module tb_mac_window_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        validi;
    logic        mode;
    logic        flush;
    logic [31:0] d32;
    logic [7:0]  d8;

    logic        v_a, ov_a, v_s, ov_s, v_p, ov_p, v_w, ov_w;
    logic [31:0] o_a, o_s;
    logic [7:0]  o_p, o_w;
    logic [1:0]  rc_a, rc_s, rc_p, rc_w;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    mac_window_pipe #(.DW(32), .OW(32), .SIGNED(0), .SAT(0)) dut_a (
        .clk(clk), .rst(rst), .validi(validi), .data_in(d32), .mode(mode), .flush(flush),
        .valido(v_a), .data_out(o_a), .ovf(ov_a), .run_cnt(rc_a)
    );

    mac_window_pipe #(.DW(32), .OW(32), .SIGNED(1), .SAT(0)) dut_s (
        .clk(clk), .rst(rst), .validi(validi), .data_in(d32), .mode(mode), .flush(flush),
        .valido(v_s), .data_out(o_s), .ovf(ov_s), .run_cnt(rc_s)
    );

    mac_window_pipe #(.DW(8), .OW(8), .SIGNED(0), .SAT(1)) dut_p (
        .clk(clk), .rst(rst), .validi(validi), .data_in(d8), .mode(mode), .flush(flush),
        .valido(v_p), .data_out(o_p), .ovf(ov_p), .run_cnt(rc_p)
    );

    mac_window_pipe #(.DW(8), .OW(8), .SIGNED(0), .SAT(0)) dut_w (
        .clk(clk), .rst(rst), .validi(validi), .data_in(d8), .mode(mode), .flush(flush),
        .valido(v_w), .data_out(o_w), .ovf(ov_w), .run_cnt(rc_w)
    );

    // Apply one cycle of inputs, then settle just after the capturing edge.
    task automatic drive(input logic v, input logic [31:0] d, input logic m, input logic f);
        @(negedge clk);
        validi = v;
        d32    = d;
        d8     = d[7:0];
        mode   = m;
        flush  = f;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        drive(1'b1, 32'd5, 1'b0, 1'b0);
        drive(1'b1, 32'd5, 1'b0, 1'b0);
        n_checks++;
        if (v_a !== 1'b0) begin n_fail++; $display("FAIL reset_valido got %0b want 0", v_a); end
        n_checks++;
        if (o_a !== 32'd0) begin n_fail++; $display("FAIL reset_data got %0d want 0", o_a); end
        n_checks++;
        if (rc_a !== 2'd0) begin n_fail++; $display("FAIL reset_run_cnt got %0d want 0", rc_a); end
        n_checks++;
        if (ov_p !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", ov_p); end
        rst = 1'b1;
        drive(1'b1, 32'd1, 1'b0, 1'b0);
        drive(1'b1, 32'd2, 1'b0, 1'b0);
        n_checks++;
        if (v_a !== 1'b0) begin n_fail++; $display("FAIL reset_refill_early got %0b want 0", v_a); end
        drive(1'b1, 32'd3, 1'b0, 1'b0);
        n_checks++;
        if (v_a !== 1'b1 || o_a !== 32'd5)
            begin n_fail++; $display("FAIL reset_first_result got v=%0b d=%0d want v=1 d=5", v_a, o_a); end
        n_checks++;
        if (rc_a !== 2'd2) begin n_fail++; $display("FAIL reset_run_full got %0d want 2", rc_a); end
    endtask

    task automatic test_basic_add;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 32'd2, 1'b0, 1'b0);
        drive(1'b1, 32'd3, 1'b0, 1'b0);
        drive(1'b1, 32'd4, 1'b0, 1'b0);
        n_checks++;
        if (v_a !== 1'b1 || o_a !== 32'd10 || ov_a !== 1'b0)
            begin n_fail++; $display("FAIL basic_add got v=%0b d=%0d o=%0b want v=1 d=10 o=0", v_a, o_a, ov_a); end
    endtask

    task automatic test_back_to_back;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 32'd2, 1'b0, 1'b0);
        drive(1'b1, 32'd3, 1'b0, 1'b0);
        drive(1'b1, 32'd4, 1'b0, 1'b0);
        n_checks++;
        if (v_a !== 1'b1 || o_a !== 32'd10)
            begin n_fail++; $display("FAIL slide_first got v=%0b d=%0d want v=1 d=10", v_a, o_a); end
        drive(1'b1, 32'd5, 1'b0, 1'b0);
        n_checks++;
        if (v_a !== 1'b1 || o_a !== 32'd17)
            begin n_fail++; $display("FAIL slide_second got v=%0b d=%0d want v=1 d=17", v_a, o_a); end
        drive(1'b0, 32'd99, 1'b0, 1'b0);
        n_checks++;
        if (v_a !== 1'b0 || o_a !== 32'd17 || rc_a !== 2'd0)
            begin n_fail++; $display("FAIL gap_hold got v=%0b d=%0d rc=%0d want v=0 d=17 rc=0", v_a, o_a, rc_a); end
    endtask

    task automatic test_gap_flush;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 32'd2, 1'b0, 1'b0);
        drive(1'b1, 32'd3, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 32'd4, 1'b0, 1'b0);
        n_checks++;
        if (v_a !== 1'b0) begin n_fail++; $display("FAIL gap_break_4 got %0b want 0", v_a); end
        drive(1'b1, 32'd5, 1'b0, 1'b0);
        n_checks++;
        if (v_a !== 1'b0 || rc_a !== 2'd2)
            begin n_fail++; $display("FAIL gap_break_5 got v=%0b rc=%0d want v=0 rc=2", v_a, rc_a); end
        drive(1'b1, 32'd6, 1'b0, 1'b0);
        n_checks++;
        if (v_a !== 1'b1 || o_a !== 32'd26)
            begin n_fail++; $display("FAIL gap_refill got v=%0b d=%0d want v=1 d=26", v_a, o_a); end
        drive(1'b1, 32'd7, 1'b0, 1'b1);
        n_checks++;
        if (v_a !== 1'b0 || rc_a !== 2'd1 || o_a !== 32'd26)
            begin n_fail++; $display("FAIL flush_valid got v=%0b rc=%0d d=%0d want v=0 rc=1 d=26", v_a, rc_a, o_a); end
        drive(1'b1, 32'd8, 1'b0, 1'b0);
        n_checks++;
        if (v_a !== 1'b0) begin n_fail++; $display("FAIL flush_second got %0b want 0", v_a); end
        drive(1'b1, 32'd9, 1'b0, 1'b0);
        n_checks++;
        if (v_a !== 1'b1 || o_a !== 32'd65)
            begin n_fail++; $display("FAIL flush_result got v=%0b d=%0d want v=1 d=65", v_a, o_a); end
        drive(1'b1, 32'd1, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        n_checks++;
        if (rc_a !== 2'd0 || o_a !== 32'd73)
            begin n_fail++; $display("FAIL flush_idle got rc=%0d d=%0d want rc=0 d=73", rc_a, o_a); end
    endtask

    task automatic test_signed_sub;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 32'd3, 1'b1, 1'b0);
        drive(1'b1, 32'd4, 1'b1, 1'b0);
        drive(1'b1, 32'd20, 1'b1, 1'b0);
        n_checks++;
        if (v_s !== 1'b1 || o_s !== 32'hFFFF_FFF8 || ov_s !== 1'b0)
            begin n_fail++; $display("FAIL signed_sub got v=%0b d=%h o=%0b want v=1 d=fffffff8 o=0", v_s, o_s, ov_s); end
        n_checks++;
        if (o_a !== 32'hFFFF_FFF8 || ov_a !== 1'b1)
            begin n_fail++; $display("FAIL unsigned_sub_wrap got d=%h o=%0b want d=fffffff8 o=1", o_a, ov_a); end
    endtask

    task automatic test_overflow;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 32'd16, 1'b0, 1'b0);
        drive(1'b1, 32'd16, 1'b0, 1'b0);
        drive(1'b1, 32'd1, 1'b0, 1'b0);
        n_checks++;
        if (v_p !== 1'b1 || o_p !== 8'd255 || ov_p !== 1'b1)
            begin n_fail++; $display("FAIL ovf_sat got v=%0b d=%0d o=%0b want v=1 d=255 o=1", v_p, o_p, ov_p); end
        n_checks++;
        if (v_w !== 1'b1 || o_w !== 8'd1 || ov_w !== 1'b1)
            begin n_fail++; $display("FAIL ovf_wrap got v=%0b d=%0d o=%0b want v=1 d=1 o=1", v_w, o_w, ov_w); end
        drive(1'b1, 32'd5, 1'b0, 1'b0);
        n_checks++;
        if (o_p !== 8'd21 || ov_p !== 1'b0 || rc_p !== 2'd2)
            begin n_fail++; $display("FAIL in_range got d=%0d o=%0b rc=%0d want d=21 o=0 rc=2", o_p, ov_p, rc_p); end
        drive(1'b1, 32'd20, 1'b1, 1'b0);
        n_checks++;
        if (o_p !== 8'd0 || ov_p !== 1'b1)
            begin n_fail++; $display("FAIL neg_sat got d=%0d o=%0b want d=0 o=1", o_p, ov_p); end
        n_checks++;
        if (o_w !== 8'd241 || ov_w !== 1'b1 || rc_w !== 2'd2)
            begin n_fail++; $display("FAIL neg_wrap got d=%0d o=%0b rc=%0d want d=241 o=1 rc=2", o_w, ov_w, rc_w); end
    endtask

    initial begin
        rst    = 1'b0;
        validi = 1'b0;
        mode   = 1'b0;
        flush  = 1'b0;
        d32    = '0;
        d8     = '0;
        test_reset();
        test_basic_add();
        test_back_to_back();
        test_gap_flush();
        test_signed_sub();
        test_overflow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
